// File: rtl/sequential_divider_pkg.sv
// Shared definitions for the restoring shift-subtract divider:
// FSM state encodings and the default operand width.
package sequential_divider_pkg;

  localparam int DEFAULT_WIDTH = 4;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_CALC = 2'd1,
    S_DONE = 2'd2
  } div_state_t;

endpackage : sequential_divider_pkg

// File: rtl/sequential_divider_control.sv
// Divider sequencer: start/ready handshake, iteration down-counter and the
// load / shift_sub strobes that steer the datapath in the top module.
//
//   state  | meaning
//   -------+---------------------------------------------------------------
//   S_IDLE | ready high; start accepted, operands loaded on that edge
//   S_CALC | one quotient bit resolved per edge; counter runs WIDTH -> 0
//   S_DONE | done pulse for one cycle; results valid, returns to S_IDLE
module sequential_divider_control
  import sequential_divider_pkg::*;
#(
  parameter int WIDTH = DEFAULT_WIDTH
) (
  input  logic clk,
  input  logic reset,
  input  logic start,
  input  logic divisor_zero,
  output logic load,
  output logic shift_sub,
  output logic ready,
  output logic done
);

  localparam int CW = $clog2(WIDTH + 1);

  div_state_t    state;
  logic [CW-1:0] count;

  // ready is the registered IDLE flag, so an accept is simply ready & start
  assign load = ready & start;

  // FSM, iteration counter and registered strobes in one sequential block
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state     <= S_IDLE;
      count     <= '0;
      ready     <= 1'b1;
      done      <= 1'b0;
      shift_sub <= 1'b0;
    end else begin
      done <= 1'b0;
      case (state)
        S_IDLE: begin
          if (start) begin
            count <= CW'(WIDTH);
            ready <= 1'b0;
            if (divisor_zero) begin
              // nothing to iterate: result is forced during the load
              state <= S_DONE;
              done  <= 1'b1;
            end else begin
              state     <= S_CALC;
              shift_sub <= 1'b1;
            end
          end
        end
        S_CALC: begin
          count <= count - CW'(1);
          if (count == CW'(1)) begin
            state     <= S_DONE;
            shift_sub <= 1'b0;
            done      <= 1'b1;
          end
        end
        S_DONE: begin
          state <= S_IDLE;
          ready <= 1'b1;
        end
        default: begin
          state     <= S_IDLE;
          ready     <= 1'b1;
          shift_sub <= 1'b0;
        end
      endcase
    end
  end

endmodule : sequential_divider_control

// File: rtl/sequential_divider.sv
// Multi-cycle restoring unsigned divider. The control block sequences the
// operation; this level holds the quotient/remainder/divisor registers and
// the trial subtractor.
module sequential_divider
  import sequential_divider_pkg::*;
#(
  parameter int WIDTH = DEFAULT_WIDTH
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic [WIDTH-1:0] dividend,
  input  logic [WIDTH-1:0] divisor,
  output logic [WIDTH-1:0] quotient,
  output logic [WIDTH-1:0] remainder,
  output logic             ready,
  output logic             done,
  output logic             div_by_zero
);

  logic             load;
  logic             shift_sub;
  logic             divisor_zero;

  // R is conceptually WIDTH+1 bits, but between iterations R < D always
  // holds, so its top bit is zero and only WIDTH bits need storing.
  logic [WIDTH-1:0] q_reg;
  logic [WIDTH-1:0] r_reg;
  logic [WIDTH-1:0] d_reg;
  logic             dbz_reg;

  logic [WIDTH:0]   r_shifted;
  logic [WIDTH:0]   trial;
  logic [WIDTH-1:0] q_next;
  logic [WIDTH-1:0] r_next;

  assign divisor_zero = (divisor == '0);

  sequential_divider_control #(
    .WIDTH(WIDTH)
  ) u_control (
    .clk         (clk),
    .reset       (reset),
    .start       (start),
    .divisor_zero(divisor_zero),
    .load        (load),
    .shift_sub   (shift_sub),
    .ready       (ready),
    .done        (done)
  );

  // One restoring step: shift {R,Q} left, trial-subtract D, keep on no borrow.
  // When r_shifted has its top bit set it exceeds D, so the trial never
  // borrows and the dropped bit in the restore path is always zero.
  always_comb begin
    r_shifted = {r_reg, q_reg[WIDTH-1]};
    trial     = r_shifted - {1'b0, d_reg};
    q_next    = q_reg << 1;
    r_next    = r_shifted[WIDTH-1:0];
    if (!trial[WIDTH]) begin
      r_next    = trial[WIDTH-1:0];
      q_next[0] = 1'b1;
    end
  end

  // Datapath registers: operand capture on accept, one step per CALC edge
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      q_reg   <= '0;
      r_reg   <= '0;
      d_reg   <= '0;
      dbz_reg <= 1'b0;
    end else if (load) begin
      d_reg <= divisor;
      if (divisor_zero) begin
        q_reg   <= '1;
        r_reg   <= dividend;
        dbz_reg <= 1'b1;
      end else begin
        q_reg   <= dividend;
        r_reg   <= '0;
        dbz_reg <= 1'b0;
      end
    end else if (shift_sub) begin
      q_reg <= q_next;
      r_reg <= r_next;
    end
  end

  assign quotient    = q_reg;
  assign remainder   = r_reg;
  assign div_by_zero = dbz_reg;

endmodule : sequential_divider

// File: tb/tb_sequential_divider.sv
// Self-checking bench for sequential_divider (WIDTH=4): directed scenarios
// plus randomized operands against an arithmetic reference (a/b, a%b).
`timescale 1ns/1ps
module tb_sequential_divider;

  localparam int WIDTH = 4;
  localparam int MAXV  = (1 << WIDTH) - 1;

  logic             clk      = 1'b0;
  logic             reset    = 1'b1;
  logic             start    = 1'b0;
  logic [WIDTH-1:0] dividend = '0;
  logic [WIDTH-1:0] divisor  = '0;
  logic [WIDTH-1:0] quotient;
  logic [WIDTH-1:0] remainder;
  logic             ready;
  logic             done;
  logic             div_by_zero;

  int vectors     = 0;
  int miscompares = 0;
  int cyc         = 0;

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  sequential_divider #(.WIDTH(WIDTH)) dut (
    .clk        (clk),
    .reset      (reset),
    .start      (start),
    .dividend   (dividend),
    .divisor    (divisor),
    .quotient   (quotient),
    .remainder  (remainder),
    .ready      (ready),
    .done       (done),
    .div_by_zero(div_by_zero)
  );

  task automatic check(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    vectors++;
    assert (observed === expected) else begin
      miscompares++;
      $error("FAIL %s: observed %0d expected %0d", tag, observed, expected);
    end
  endtask

  // Arithmetic reference: plain integer divide, with the defined /0 result
  function automatic void ref_div(input int a, input int b, output int q, output int r, output int z);
    if (b == 0) begin
      q = MAXV;
      r = a;
      z = 1;
    end else begin
      q = a / b;
      r = a % b;
      z = 0;
    end
  endfunction

  // One operation: pulse start, count edges to done, check results/handshake.
  // With inject set, a second start (14/2) is pulsed during CALC.
  task automatic run_op(input int a, input int b, input string tag, input bit inject);
    int eq, er, ez, lat;
    bit seen;
    ref_div(a, b, eq, er, ez);
    @(negedge clk);
    check({tag, ":ready_idle"}, 32'(ready), 32'd1);
    start    = 1'b1;
    dividend = WIDTH'(a);
    divisor  = WIDTH'(b);
    @(posedge clk);
    lat  = 0;
    seen = 1'b0;
    for (int i = 0; i < 3 * WIDTH; i++) begin
      @(negedge clk);
      if (inject && i == 1) begin
        start    = 1'b1;
        dividend = 4'd14;
        divisor  = 4'd2;
      end else begin
        start    = 1'b0;
        dividend = WIDTH'($urandom);
        divisor  = WIDTH'($urandom);
      end
      if (done) begin
        seen = 1'b1;
        break;
      end
      check({tag, ":ready_busy"}, 32'(ready), 32'd0);
      @(posedge clk);
      lat++;
    end
    check({tag, ":done_seen"}, 32'(seen), 32'd1);
    check({tag, ":latency"}, 32'(lat), (ez != 0) ? 32'd0 : 32'(WIDTH));
    check({tag, ":quotient"}, 32'(quotient), 32'(eq));
    check({tag, ":remainder"}, 32'(remainder), 32'(er));
    check({tag, ":div_by_zero"}, 32'(div_by_zero), 32'(ez));
    if (ez == 0)
      check({tag, ":invariant"}, 32'(quotient) * 32'(b) + 32'(remainder), 32'(a));
    @(posedge clk);
    #1;
    check({tag, ":done_pulse_end"}, 32'(done), 32'd0);
    check({tag, ":ready_back"}, 32'(ready), 32'd1);
    check({tag, ":quotient_held"}, 32'(quotient), 32'(eq));
  endtask

  initial begin
    int t0, a, b;
    bit seen;

    // Reset: outputs take their reset values while reset is low
    #2 reset = 1'b0;
    #28;
    check("reset:quotient", 32'(quotient), 32'd0);
    check("reset:remainder", 32'(remainder), 32'd0);
    check("reset:ready", 32'(ready), 32'd1);
    check("reset:done", 32'(done), 32'd0);
    check("reset:div_by_zero", 32'(div_by_zero), 32'd0);
    @(negedge clk);
    reset = 1'b1;

    // Directed operations
    run_op(11, 3, "op_11_3", 1'b0);
    run_op(9, 11, "op_9_11", 1'b0);
    run_op(15, 1, "op_15_1", 1'b0);
    run_op(7, 0, "op_7_0", 1'b0);
    run_op(11, 3, "op_after_dbz", 1'b0);
    run_op(0, 5, "op_0_5", 1'b0);
    run_op(15, 15, "op_15_15", 1'b0);

    // Start during CALC is ignored
    run_op(11, 3, "ignore_start", 1'b1);

    // Start held high: one operation every WIDTH+2 cycles
    @(negedge clk);
    start    = 1'b1;
    dividend = 4'd12;
    divisor  = 4'd5;
    seen     = 1'b0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (done) begin
        seen = 1'b1;
        break;
      end
    end
    check("held:first_done", 32'(seen), 32'd1);
    t0 = cyc;
    for (int n = 0; n < 3; n++) begin
      seen = 1'b0;
      for (int i = 0; i < 20; i++) begin
        @(negedge clk);
        if (done) begin
          seen = 1'b1;
          break;
        end
      end
      check("held:done_seen", 32'(seen), 32'd1);
      check("held:period", 32'(cyc - t0), 32'(WIDTH + 2));
      check("held:quotient", 32'(quotient), 32'd2);
      check("held:remainder", 32'(remainder), 32'd2);
      t0 = cyc;
    end
    start = 1'b0;
    @(negedge clk);

    // Reset asserted during the second CALC cycle
    @(negedge clk);
    start    = 1'b1;
    dividend = 4'd11;
    divisor  = 4'd3;
    @(posedge clk);
    @(negedge clk);
    start = 1'b0;
    @(posedge clk);
    #2 reset = 1'b0;
    #1;
    check("midreset:quotient", 32'(quotient), 32'd0);
    check("midreset:remainder", 32'(remainder), 32'd0);
    check("midreset:ready", 32'(ready), 32'd1);
    check("midreset:done", 32'(done), 32'd0);
    check("midreset:div_by_zero", 32'(div_by_zero), 32'd0);
    @(negedge clk);
    reset = 1'b1;
    seen  = 1'b0;
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      if (done) seen = 1'b1;
    end
    check("midreset:no_done", 32'(seen), 32'd0);
    run_op(13, 4, "op_13_4", 1'b0);

    // Randomized operands against the reference
    for (int n = 0; n < 30; n++) begin
      a = int'($urandom_range(0, MAXV));
      b = int'($urandom_range(0, MAXV));
      run_op(a, b, "random", 1'b0);
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

  initial begin
    #1ms;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "time limit");
  end

endmodule : tb_sequential_divider
